// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow/misalignment exception detection and store formatting.
// Latency: 1 cycle, and every output is registered.
// Backpressure: stall holds all state; flush, or ex_valid=0, loads a bubble.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   stall, flush        hazard-unit controls (rst > flush > stall > load)
//   ex_*                EX-stage instruction fields
//   mem_*               registered MEM-stage fields; enables are suppressed on exception
//   mem_exc_*           exception flag, code and faulting address
module ex_mem_reg #(
  parameter logic [4:0] OV_CODE   = 5'h0C,
  parameter logic [4:0] ADEL_CODE = 5'h04,
  parameter logic [4:0] ADES_CODE = 5'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_overflow,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_wreg_addr,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_load_unsigned,
  input  logic [31:0] ex_pc,
  output logic        mem_valid,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_wreg_addr,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic [1:0]  mem_mem_size,
  output logic        mem_load_unsigned,
  output logic [31:0] mem_pc,
  output logic        mem_exc_valid,
  output logic [4:0]  mem_exc_code,
  output logic [31:0] mem_badvaddr
);

  logic        mis;
  logic        adel;
  logic        ades;
  logic        exc;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;

  always_comb begin
    // Halfwords need bit 0 clear, words need both low bits clear; bytes are always aligned.
    mis = ((ex_mem_size == 2'b01) && ex_alu_result[0]) ||
          (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00));
    // Overflow masks address faults; a (illegal) load+store pair reports as a load fault.
    adel = mis && ex_memread && !ex_overflow;
    ades = mis && ex_memwrite && !ex_memread && !ex_overflow;
    exc  = ex_overflow || adel || ades;

    exc_code = 5'h00;
    if (ex_overflow)  exc_code = OV_CODE;
    else if (adel)    exc_code = ADEL_CODE;
    else if (ades)    exc_code = ADES_CODE;

    badvaddr = (adel || ades) ? ex_alu_result : 32'h0;

    // Replicate store data across the lanes so the memory only has to honour byte enables.
    fmt_wdata = ex_rt_data;
    fmt_be    = 4'b0000;
    if (ex_memwrite) begin
      case (ex_mem_size)
        2'b00: begin
          fmt_wdata = {4{ex_rt_data[7:0]}};
          fmt_be    = 4'b0001 << ex_alu_result[1:0];
        end
        2'b01: begin
          fmt_wdata = {2{ex_rt_data[15:0]}};
          fmt_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = ex_rt_data;
          fmt_be    = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // Reset, flush, and an invalid instruction (when not stalled) all produce the same bubble.
    if (rst || flush || (!stall && !ex_valid)) begin
      mem_valid         <= 1'b0;
      mem_alu_result    <= 32'h0;
      mem_wreg_addr     <= 5'h0;
      mem_regwrite      <= 1'b0;
      mem_memread       <= 1'b0;
      mem_memwrite      <= 1'b0;
      mem_wdata         <= 32'h0;
      mem_byte_en       <= 4'h0;
      mem_mem_size      <= 2'b00;
      mem_load_unsigned <= 1'b0;
      mem_pc            <= 32'h0;
      mem_exc_valid     <= 1'b0;
      mem_exc_code      <= 5'h0;
      mem_badvaddr      <= 32'h0;
    end else if (!stall) begin
      mem_valid         <= 1'b1;
      mem_alu_result    <= ex_alu_result;
      mem_wreg_addr     <= ex_wreg_addr;
      mem_regwrite      <= ex_regwrite && !exc;
      mem_memread       <= ex_memread && !exc;
      mem_memwrite      <= ex_memwrite && !exc;
      mem_wdata         <= fmt_wdata;
      mem_byte_en       <= exc ? 4'h0 : fmt_be;
      mem_mem_size      <= ex_mem_size;
      mem_load_unsigned <= ex_load_unsigned;
      mem_pc            <= ex_pc;
      mem_exc_valid     <= exc;
      mem_exc_code      <= exc_code;
      mem_badvaddr      <= badvaddr;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vectors push hand-computed expectations into a queue,
// and a monitor compares every registered output word one cycle later.
// Stall cycles push the held value again; flush/reset/invalid push the all-zero bubble.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  size;
    logic        lu;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
  } out_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_overflow, ex_regwrite, ex_memread, ex_memwrite, ex_load_unsigned;
  logic [31:0] ex_alu_result, ex_rt_data, ex_pc;
  logic [4:0]  ex_wreg_addr;
  logic [1:0]  ex_mem_size;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_load_unsigned, mem_exc_valid;
  logic [31:0] mem_alu_result, mem_wdata, mem_pc, mem_badvaddr;
  logic [4:0]  mem_wreg_addr, mem_exc_code;
  logic [3:0]  mem_byte_en;
  logic [1:0]  mem_mem_size;

  out_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  bit    stim_done = 1'b0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_overflow(ex_overflow),
    .ex_rt_data(ex_rt_data), .ex_wreg_addr(ex_wreg_addr), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_mem_size(ex_mem_size),
    .ex_load_unsigned(ex_load_unsigned), .ex_pc(ex_pc),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_wreg_addr(mem_wreg_addr),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_mem_size(mem_mem_size),
    .mem_load_unsigned(mem_load_unsigned), .mem_pc(mem_pc), .mem_exc_valid(mem_exc_valid),
    .mem_exc_code(mem_exc_code), .mem_badvaddr(mem_badvaddr)
  );

  function automatic out_t mk(logic v, logic [31:0] alu, logic [4:0] wreg, logic rw, logic mr,
                              logic mw, logic [31:0] wdata, logic [3:0] be, logic [1:0] size,
                              logic lu, logic [31:0] pc, logic exc, logic [4:0] code,
                              logic [31:0] badv);
    out_t o;
    o.valid = v;   o.alu = alu;     o.wreg = wreg; o.rw = rw;   o.mr = mr;  o.mw = mw;
    o.wdata = wdata; o.be = be;     o.size = size; o.lu = lu;   o.pc = pc;
    o.exc = exc;   o.code = code;   o.bad = badv;
    return o;
  endfunction

  task automatic set_in(logic v, logic [31:0] alu, logic ov, logic [31:0] rt, logic [4:0] wreg,
                        logic rw, logic mr, logic mw, logic [1:0] size, logic lu, logic [31:0] pc);
    ex_valid = v;   ex_alu_result = alu; ex_overflow = ov; ex_rt_data = rt;
    ex_wreg_addr = wreg; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_mem_size = size;  ex_load_unsigned = lu; ex_pc = pc;
  endtask

  // Queue the expectation for the edge that is about to sample the current inputs.
  task automatic step(string nm, out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: one registered output word per rising edge, checked 1 time unit after it.
  initial begin
    out_t  act, e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = mk(mem_valid, mem_alu_result, mem_wreg_addr, mem_regwrite, mem_memread,
                 mem_memwrite, mem_wdata, mem_byte_en, mem_mem_size, mem_load_unsigned,
                 mem_pc, mem_exc_valid, mem_exc_code, mem_badvaddr);
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end else if (stim_done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t zero, a;
    zero = '0;
    stall = 1'b0;
    flush = 1'b0;

    // Reset with busy, exception-provoking inputs.
    rst = 1'b1;
    set_in(1, 32'hFFFF_FFFF, 1, 32'h1234_5678, 5'd31, 1, 1, 1, 2'b11, 1, 32'hDEAD_BEEF);
    step("reset0", zero);
    step("reset1", zero);
    total++;
    if (mem_valid !== 1'b0 || mem_exc_valid !== 1'b0 || mem_pc !== 32'h0) begin
        bad++;
        $display("FAIL reset_direct: got valid=%b exc=%b pc=%h expected 0 0 0",
                 mem_valid, mem_exc_valid, mem_pc);
    end
    rst = 1'b0;

    set_in(1, 32'h10, 0, 32'h0, 5'd8, 1, 0, 0, 2'b10, 0, 32'h0040_0000);
    step("add", mk(1, 32'h10, 5'd8, 1, 0, 0, 32'h0, 4'h0, 2'b10, 0, 32'h0040_0000, 0, 5'h0, 32'h0));
    total++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'h10 || mem_regwrite !== 1'b1 ||
        mem_wreg_addr !== 5'd8 || mem_exc_valid !== 1'b0) begin
        bad++;
        $display("FAIL add_direct: got valid=%b alu=%h rw=%b wreg=%0d exc=%b expected 1 10 1 8 0",
                 mem_valid, mem_alu_result, mem_regwrite, mem_wreg_addr, mem_exc_valid);
    end

    set_in(1, 32'h8000_0000, 1, 32'h0, 5'd3, 1, 0, 0, 2'b10, 0, 32'hBFC0_0100);
    step("ovf", mk(1, 32'h8000_0000, 5'd3, 0, 0, 0, 32'h0, 4'h0, 2'b10, 0, 32'hBFC0_0100, 1, 5'h0C, 32'h0));
    total++;
    if (mem_exc_code !== 5'h0C || mem_regwrite !== 1'b0 || mem_pc !== 32'hBFC0_0100) begin
        bad++;
        $display("FAIL ovf_direct: got code=%h rw=%b pc=%h expected 0c 0 bfc00100",
                 mem_exc_code, mem_regwrite, mem_pc);
    end

    set_in(1, 32'h1003, 0, 32'hAABB_CCDD, 5'd0, 0, 0, 1, 2'b00, 0, 32'h0040_0010);
    step("sb3", mk(1, 32'h1003, 5'd0, 0, 0, 1, 32'hDDDD_DDDD, 4'b1000, 2'b00, 0, 32'h0040_0010, 0, 5'h0, 32'h0));
    total++;
    if (mem_byte_en !== 4'b1000 || mem_wdata !== 32'hDDDD_DDDD) begin
        bad++;
        $display("FAIL sb3_direct: got be=%b wdata=%h expected 1000 dddddddd",
                 mem_byte_en, mem_wdata);
    end

    set_in(1, 32'h1001, 0, 32'hAABB_CCDD, 5'd0, 0, 0, 1, 2'b00, 0, 32'h0040_0014);
    step("sb1", mk(1, 32'h1001, 5'd0, 0, 0, 1, 32'hDDDD_DDDD, 4'b0010, 2'b00, 0, 32'h0040_0014, 0, 5'h0, 32'h0));

    set_in(1, 32'h1002, 0, 32'hAABB_CCDD, 5'd0, 0, 0, 1, 2'b01, 0, 32'h0040_0018);
    step("sh2", mk(1, 32'h1002, 5'd0, 0, 0, 1, 32'hCCDD_CCDD, 4'b1100, 2'b01, 0, 32'h0040_0018, 0, 5'h0, 32'h0));

    set_in(1, 32'h1000, 0, 32'hAABB_CCDD, 5'd0, 0, 0, 1, 2'b01, 0, 32'h0040_001C);
    step("sh0", mk(1, 32'h1000, 5'd0, 0, 0, 1, 32'hCCDD_CCDD, 4'b0011, 2'b01, 0, 32'h0040_001C, 0, 5'h0, 32'h0));

    set_in(1, 32'h1000, 0, 32'hAABB_CCDD, 5'd0, 0, 0, 1, 2'b10, 0, 32'h0040_0020);
    step("sw", mk(1, 32'h1000, 5'd0, 0, 0, 1, 32'hAABB_CCDD, 4'b1111, 2'b10, 0, 32'h0040_0020, 0, 5'h0, 32'h0));

    set_in(1, 32'h1002, 0, 32'h0, 5'd9, 1, 1, 0, 2'b10, 0, 32'h0040_0024);
    step("lw_adel", mk(1, 32'h1002, 5'd9, 0, 0, 0, 32'h0, 4'h0, 2'b10, 0, 32'h0040_0024, 1, 5'h04, 32'h1002));
    total++;
    if (mem_exc_code !== 5'h04 || mem_badvaddr !== 32'h1002 || mem_memread !== 1'b0) begin
        bad++;
        $display("FAIL adel_direct: got code=%h bad=%h mr=%b expected 04 1002 0",
                 mem_exc_code, mem_badvaddr, mem_memread);
    end

    set_in(1, 32'h1001, 0, 32'h0, 5'd0, 0, 0, 1, 2'b01, 0, 32'h0040_0028);
    step("sh_ades", mk(1, 32'h1001, 5'd0, 0, 0, 0, 32'h0, 4'h0, 2'b01, 0, 32'h0040_0028, 1, 5'h05, 32'h1001));

    set_in(1, 32'h1003, 0, 32'h0, 5'd4, 1, 1, 0, 2'b00, 1, 32'h0040_002C);
    step("lbu", mk(1, 32'h1003, 5'd4, 1, 1, 0, 32'h0, 4'h0, 2'b00, 1, 32'h0040_002C, 0, 5'h0, 32'h0));

    set_in(1, 32'h1002, 0, 32'h0, 5'd5, 0, 1, 1, 2'b11, 0, 32'h0040_0030);
    step("rdwr_adel", mk(1, 32'h1002, 5'd5, 0, 0, 0, 32'h0, 4'h0, 2'b11, 0, 32'h0040_0030, 1, 5'h04, 32'h1002));

    // Instruction A, then three stalled cycles with changing inputs.
    set_in(1, 32'h2000, 0, 32'h0, 5'd10, 1, 1, 0, 2'b10, 0, 32'h0040_0100);
    a = mk(1, 32'h2000, 5'd10, 1, 1, 0, 32'h0, 4'h0, 2'b10, 0, 32'h0040_0100, 0, 5'h0, 32'h0);
    step("instA", a);
    stall = 1'b1;
    set_in(1, 32'h3000, 0, 32'h5555_5555, 5'd11, 1, 0, 1, 2'b00, 1, 32'h0040_0104);
    step("stall1", a);
    set_in(1, 32'h3003, 1, 32'h6666_6666, 5'd12, 0, 1, 0, 2'b01, 0, 32'h0040_0108);
    step("stall2", a);
    set_in(0, 32'h0, 0, 32'h0, 5'd0, 0, 0, 0, 2'b00, 0, 32'h0);
    step("stall3", a);
    total++;
    if (mem_alu_result !== 32'h2000 || mem_wreg_addr !== 5'd10 || mem_pc !== 32'h0040_0100) begin
        bad++;
        $display("FAIL stall_direct: got alu=%h wreg=%0d pc=%h expected 2000 10 00400100",
                 mem_alu_result, mem_wreg_addr, mem_pc);
    end
    flush = 1'b1;
    set_in(1, 32'h4000, 0, 32'h7777_7777, 5'd13, 1, 0, 1, 2'b10, 0, 32'h0040_010C);
    step("stall_flush", zero);
    total++;
    if (mem_valid !== 1'b0 || mem_regwrite !== 1'b0 || mem_memread !== 1'b0 ||
        mem_memwrite !== 1'b0 || mem_byte_en !== 4'h0) begin
        bad++;
        $display("FAIL stall_flush_direct: got valid=%b rw=%b mr=%b mw=%b be=%b expected all 0",
                 mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_byte_en);
    end
    stall = 1'b0;

    // Plain flush with a valid instruction present.
    set_in(1, 32'h4004, 0, 32'h0, 5'd14, 1, 0, 0, 2'b10, 0, 32'h0040_0110);
    step("flush", zero);
    flush = 1'b0;

    // Reset while a held instruction is stalled discards it.
    set_in(1, 32'h5000, 0, 32'h0, 5'd15, 1, 0, 0, 2'b10, 0, 32'h0040_0200);
    step("instB", mk(1, 32'h5000, 5'd15, 1, 0, 0, 32'h0, 4'h0, 2'b10, 0, 32'h0040_0200, 0, 5'h0, 32'h0));
    stall = 1'b1;
    rst = 1'b1;
    step("stall_rst", zero);
    stall = 1'b0;
    rst = 1'b0;

    // Overflow wins over a misaligned store.
    set_in(1, 32'h1001, 1, 32'h0, 5'd0, 0, 0, 1, 2'b01, 0, 32'h0040_0300);
    step("ov_over_ades", mk(1, 32'h1001, 5'd0, 0, 0, 0, 32'h0, 4'h0, 2'b01, 0, 32'h0040_0300, 1, 5'h0C, 32'h0));
    total++;
    if (mem_exc_code !== 5'h0C || mem_badvaddr !== 32'h0) begin
        bad++;
        $display("FAIL ov_over_ades_direct: got code=%h bad=%h expected 0c 0",
                 mem_exc_code, mem_badvaddr);
    end

    // Invalid store loads a bubble.
    set_in(0, 32'h1000, 0, 32'h1234, 5'd2, 0, 0, 1, 2'b10, 0, 32'h0040_0304);
    step("invalid_store", zero);
    total++;
    if (mem_byte_en !== 4'h0 || mem_valid !== 1'b0) begin
        bad++;
        $display("FAIL invalid_store_direct: got be=%b valid=%b expected 0 0",
                 mem_byte_en, mem_valid);
    end

    stim_done = 1'b1;
  end

endmodule
